uart_msg_scheduler: RTL and testbench
=====================================

UART_MSG_SCHEDULER -- requirements
Module: uart_msg_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters (fixed at 4 for this release).
REQ-002 Parameter HDR0, default 8'h53: first header byte ('S').
REQ-003 Parameter HDR1, default 8'h4D: second header byte ('M').
REQ-004 Parameter GAP_CLKS, default 434: idle clocks inserted between frames (one bit time).
REQ-005 Parameter ACC_TIMEOUT, default 8: max clocks to wait for the transmitter to accept a byte.
REQ-006 CLOCK  in  1  single clock; one clock; reset is asynchronous and active-high.
REQ-007 RESET  in  1  asynchronous, active-high reset.
REQ-008 REQ  in  4  per-requester frame request, level, held until ACK.
REQ-009 REQ_DATA  in  32  payload bytes; requester i on bits [8i+7:8i].
REQ-010 ACK  out  4  one-hot, one-cycle pulse when requester i's payload is latched.
REQ-011 TX_DATA_VALID  out  1  byte-valid to UART transmitter.
REQ-012 TX_BYTE  out  8  byte to UART transmitter.
REQ-013 TX_DONE  in  1  transmitter done/idle flag: low while start/data bits are sent, high in idle/stop bit.
REQ-014 BUSY  out  1  high from grant until end of inter-frame gap.
REQ-015 ERROR  out  1  sticky accept-timeout flag, cleared only by RESET.
REQ-016 FRAME_COUNT  out  16  completed frames, wraps 16'hFFFF -> 0.

Function
REQ-017 Frame = 4 bytes in order: HDR0, HDR1, ID (= {6'b0, granted index} + 1), latched payload.
REQ-018 States: IDLE, ARB, LOAD, SEND, WAIT_ACC, WAIT_DONE, NEXT, GAP.
REQ-019 IDLE -> ARB when any REQ bit high and ERROR low; with ERROR high, remain in IDLE.
REQ-020 ARB: round-robin; search starts at last-granted index + 1 (mod 4); after reset, search starts at 0; one cycle.
REQ-021 LOAD: latch the granted payload and index, pulse ACK[index] exactly one cycle, clear byte index, -> SEND.
REQ-022 A REQ dropped between ARB and LOAD is still served; the latched payload is the value present in the LOAD cycle.
REQ-023 SEND: drive TX_BYTE for the current byte index, assert TX_DATA_VALID, clear accept counter, -> WAIT_ACC.
REQ-024 WAIT_ACC: hold TX_DATA_VALID and TX_BYTE stable; on TX_DONE low, deassert TX_DATA_VALID and go to WAIT_DONE.
REQ-025 WAIT_ACC: if TX_DONE is still high after ACC_TIMEOUT clocks, set ERROR, deassert TX_DATA_VALID, go to IDLE, and do not increment FRAME_COUNT.
REQ-026 WAIT_DONE: on TX_DONE high -> NEXT; no timeout in this state.
REQ-027 NEXT: if byte index = 3, increment FRAME_COUNT and go to GAP with gap counter = 0; else increment the byte index and go to SEND.
REQ-028 GAP: count to GAP_CLKS-1, then go to IDLE; REQ changes during GAP are ignored.
REQ-029 TX_BYTE holds its last value when TX_DATA_VALID is low.
REQ-030 BUSY is high in all states except IDLE and ARB.
REQ-031 At most one ACK bit is high in any cycle; ACK never pulses while a frame is in flight.

Reset
REQ-032 On RESET, asynchronously: state=IDLE, ACK=0, TX_DATA_VALID=0, TX_BYTE=0, BUSY=0, ERROR=0, FRAME_COUNT=0, round-robin pointer=3, all counters=0.
REQ-033 RESET asserted mid-frame aborts the frame immediately; no ACK and no count are generated for it.

Structure
REQ-034 The state encoding, HDR0/HDR1 defaults and frame length (4) belong in a shared uart package, also used by the transmitter bench.
REQ-035 The round-robin arbiter is a sub-module, rr_arbiter4: inputs REQ and pointer, output a one-hot grant (combinational); the scheduler registers the grant.
REQ-036 The scheduler instantiates no UART; it connects to the transmitter through TX_DATA_VALID, TX_BYTE and TX_DONE only.

Verification
REQ-037 REQ=4'b0100, REQ_DATA[23:16]=8'h08, transmitter model -> ACK=4'b0100 once; TX bytes 53,4D,03,08; FRAME_COUNT=1.
REQ-038 REQ=4'b1111 held for 4 frames -> grants in order 0,1,2,3; ID bytes 01,02,03,04; gap >=434 clocks between frames.
REQ-039 TX_DONE tied high -> ERROR=1 after 8 clocks in WAIT_ACC; TX_DATA_VALID=0; no further frames after REQ is reasserted.
REQ-040 RESET pulsed during byte 2 of a frame -> all outputs at reset values the same cycle; the next frame starts at requester 0.
REQ-041 REQ pulsed for one cycle on requester 1 -> exactly one frame with ID 02; no repeat.
REQ-042 FRAME_COUNT preloaded near wrap by forcing 65535 frames -> 16'hFFFF, then 0 after the next frame.

Source files
------------

// File: rtl/uart_msg_scheduler_pkg.sv
// Shared definitions for the UART message scheduler: FSM encoding, frame
// header defaults and small index helpers.
package uart_msg_scheduler_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int FRAME_LEN   = 4;

  localparam logic [7:0] HDR0_DEF = 8'h53;
  localparam logic [7:0] HDR1_DEF = 8'h4D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LOAD,
    S_SEND,
    S_WAIT_ACC,
    S_WAIT_DONE,
    S_NEXT,
    S_GAP
  } state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

  // Frame ID is 1-based so that an all-zero byte never appears as an ID.
  function automatic logic [7:0] frame_id(input logic [1:0] idx);
    return {6'b0, idx} + 8'd1;
  endfunction

endpackage

// File: rtl/uart_msg_scheduler_if.sv
// Requester and transmitter handshake bundle; master is the scheduler side.
interface uart_msg_scheduler_if;
  import uart_msg_scheduler_pkg::*;

  logic [NUM_REQ_DEF-1:0]   req;
  logic [8*NUM_REQ_DEF-1:0] req_data;
  logic [NUM_REQ_DEF-1:0]   ack;
  logic                     tx_data_valid;
  logic [7:0]               tx_byte;
  logic                     tx_done;

  modport master (
    input  req, req_data, tx_done,
    output ack, tx_data_valid, tx_byte
  );

  modport slave (
    output req, req_data, tx_done,
    input  ack, tx_data_valid, tx_byte
  );

endinterface

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter; search begins one past i_ptr.
module rr_arbiter4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [3:0] o_grant
);

  logic [1:0] w_idx;

  // Walk farthest-to-nearest so the nearest requester overwrites the others.
  always_comb begin
    o_grant = '0;
    w_idx   = '0;
    for (int k = 4; k >= 1; k--) begin
      w_idx = i_ptr + 2'(k);
      if (i_req[w_idx]) o_grant = 4'b0001 << w_idx;
    end
  end

endmodule

// File: rtl/uart_msg_scheduler.sv
// Round-robin scheduler framing requester payloads as HDR0, HDR1, ID, DATA
// toward an external UART transmitter, with accept timeout and frame gap.
module uart_msg_scheduler
  import uart_msg_scheduler_pkg::*;
#(
  parameter int         NUM_REQ     = NUM_REQ_DEF,
  parameter logic [7:0] HDR0        = HDR0_DEF,
  parameter logic [7:0] HDR1        = HDR1_DEF,
  parameter int         GAP_CLKS    = 434,
  parameter int         ACC_TIMEOUT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  uart_msg_scheduler_if.master if_bus,
  output logic                 o_busy,
  output logic                 o_error,
  output logic [15:0]          o_frame_count
);

  localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam int AW = (ACC_TIMEOUT > 1) ? $clog2(ACC_TIMEOUT) : 1;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_req_snap;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_ack;
  logic [1:0]           r_ptr;
  logic [1:0]           r_idx;
  logic [7:0]           r_payload;
  logic [1:0]           r_byte_idx;
  logic [AW-1:0]        r_acc_cnt;
  logic [GW-1:0]        r_gap_cnt;
  logic                 r_tx_valid;
  logic [7:0]           r_tx_byte;
  logic                 r_busy;
  logic                 r_error;
  logic [15:0]          r_frame_count;

  logic [NUM_REQ-1:0]   w_grant;
  logic [1:0]           w_load_idx;
  logic [7:0]           w_next_byte;

  // Arbitrate over the request snapshot taken in IDLE so a one-cycle
  // request pulse is still served.
  rr_arbiter4 u_arb (
    .i_req   (r_req_snap),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  assign w_load_idx = onehot_to_idx(r_grant);

  always_comb begin
    w_next_byte = r_payload;
    case (r_byte_idx)
      2'd0:    w_next_byte = HDR0;
      2'd1:    w_next_byte = HDR1;
      2'd2:    w_next_byte = frame_id(r_idx);
      default: w_next_byte = r_payload;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_req_snap    <= '0;
      r_grant       <= '0;
      r_ack         <= '0;
      r_ptr         <= 2'd3;
      r_idx         <= '0;
      r_payload     <= '0;
      r_byte_idx    <= '0;
      r_acc_cnt     <= '0;
      r_gap_cnt     <= '0;
      r_tx_valid    <= 1'b0;
      r_tx_byte     <= '0;
      r_busy        <= 1'b0;
      r_error       <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if ((|if_bus.req) && !r_error) begin
            r_req_snap <= if_bus.req;
            r_state    <= S_ARB;
          end
        end
        S_ARB: begin
          r_grant <= w_grant;
          r_busy  <= 1'b1;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_idx      <= w_load_idx;
          r_payload  <= if_bus.req_data[{w_load_idx, 3'b000} +: 8];
          r_ack      <= r_grant;
          r_ptr      <= w_load_idx;
          r_byte_idx <= '0;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          r_tx_byte  <= w_next_byte;
          r_tx_valid <= 1'b1;
          r_acc_cnt  <= '0;
          r_state    <= S_WAIT_ACC;
        end
        S_WAIT_ACC: begin
          if (!if_bus.tx_done) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_WAIT_DONE;
          end else if (r_acc_cnt == AW'(ACC_TIMEOUT - 1)) begin
            r_error    <= 1'b1;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_acc_cnt <= r_acc_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (if_bus.tx_done) r_state <= S_NEXT;
        end
        S_NEXT: begin
          if (r_byte_idx == 2'(FRAME_LEN - 1)) begin
            r_frame_count <= r_frame_count + 16'd1;
            r_gap_cnt     <= '0;
            r_state       <= S_GAP;
          end else begin
            r_byte_idx <= r_byte_idx + 2'd1;
            r_state    <= S_SEND;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GW'(GAP_CLKS - 1)) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign if_bus.ack           = r_ack;
  assign if_bus.tx_data_valid = r_tx_valid;
  assign if_bus.tx_byte       = r_tx_byte;
  assign o_busy               = r_busy;
  assign o_error              = r_error;
  assign o_frame_count        = r_frame_count;

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Directed bench for uart_msg_scheduler with a simple transmitter model.
module tb_uart_msg_scheduler;
  import uart_msg_scheduler_pkg::*;

  logic        clk;
  logic        rst;
  logic        busy;
  logic        error;
  logic [15:0] fc;
  logic        tx_en;

  uart_msg_scheduler_if bus ();

  uart_msg_scheduler dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .if_bus        (bus),
    .o_busy        (busy),
    .o_error       (error),
    .o_frame_count (fc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] cap[$];
  logic [3:0] ack_q[$];
  int         gap_q[$];
  int         valid_rises = 0;
  int         ack_multi = 0;
  logic       prev_valid = 1'b0;
  logic [15:0] prev_fc = 16'd0;
  int         gap_run = 0;
  bit         gap_arm = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: takes a byte when valid, drops done for 3 clocks.
  initial begin
    bus.tx_done = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tx_en && bus.tx_data_valid && bus.tx_done) begin
        cap.push_back(bus.tx_byte);
        bus.tx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.tx_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.ack != 4'b0) begin
      ack_q.push_back(bus.ack);
      if (!$onehot(bus.ack)) ack_multi++;
    end
    if (rst) gap_arm = 1'b0;
    else if (fc == 16'(prev_fc + 16'd1)) begin
      gap_arm = 1'b1;
      gap_run = 0;
    end else gap_run++;
    if (bus.tx_data_valid && !prev_valid) begin
      valid_rises++;
      if (gap_arm) begin
        gap_q.push_back(gap_run);
        gap_arm = 1'b0;
      end
    end
    prev_valid = bus.tx_data_valid;
    prev_fc    = fc;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ack(input int budget, output logic [3:0] seen);
    seen = 4'b0;
    for (int i = 0; i < budget && seen == 4'b0; i++) begin
      @(negedge clk);
      seen = bus.ack;
    end
  endtask

  task automatic wait_fc(input logic [15:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (fc == target && !busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.ack, bus.tx_data_valid, bus.tx_byte, busy, error, fc} !== 31'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ack=%b v=%b byte=%h busy=%b err=%b fc=%h, want all zero",
               bus.ack, bus.tx_data_valid, bus.tx_byte, busy, error, fc);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [7:0] exp[4];
    logic [3:0] seen;
    bit ok;
    int s_cap, s_ack;
    exp = '{8'h53, 8'h4D, 8'h03, 8'h08};
    do_reset();
    s_cap = cap.size();
    s_ack = ack_q.size();
    bus.req_data = 32'hDD08BBAA;
    bus.req = 4'b0100;
    wait_ack(20, seen);
    bus.req = 4'b0000;
    n_cmp++;
    if (seen !== 4'b0100) begin
      n_bad++;
      $display("FAIL single_ack: got %b want %b", seen, 4'b0100);
    end
    wait_fc(16'd1, 1000, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL single_done: fc=%h busy=%b want fc=1 idle", fc, busy); end
    @(negedge clk);
    n_cmp++;
    if (ack_q.size() - s_ack != 1) begin
      n_bad++;
      $display("FAIL single_ack_count: got %0d want 1", ack_q.size() - s_ack);
    end
    n_cmp++;
    if (cap.size() - s_cap != 4) begin
      n_bad++;
      $display("FAIL single_byte_count: got %0d want 4", cap.size() - s_cap);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cap[s_cap + i] !== exp[i]) begin
        n_bad++;
        $display("FAIL single_byte%0d: got %h want %h", i, cap[s_cap + i], exp[i]);
      end
    end
    n_cmp++;
    if (fc !== 16'd1) begin n_bad++; $display("FAIL single_fc: got %h want 0001", fc); end
  endtask

  task automatic test_round_robin;
    bit ok;
    int s_cap, s_ack, s_gap;
    do_reset();
    s_cap = cap.size();
    s_ack = ack_q.size();
    s_gap = gap_q.size();
    bus.req_data = 32'h44332211;
    bus.req = 4'b1111;
    wait_fc(16'd4, 3000, ok);
    bus.req = 4'b0000;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rr_done: fc=%h want 0004", fc); end
    @(negedge clk);
    n_cmp++;
    if (ack_q.size() - s_ack != 4) begin
      n_bad++;
      $display("FAIL rr_ack_count: got %0d want 4", ack_q.size() - s_ack);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (ack_q[s_ack + k] !== (4'b0001 << k)) begin
        n_bad++;
        $display("FAIL rr_grant%0d: got %b want %b", k, ack_q[s_ack + k], 4'b0001 << k);
      end
      n_cmp++;
      if (cap[s_cap + 4*k + 2] !== 8'(k + 1)) begin
        n_bad++;
        $display("FAIL rr_id%0d: got %h want %h", k, cap[s_cap + 4*k + 2], 8'(k + 1));
      end
      n_cmp++;
      if (cap[s_cap + 4*k + 3] !== 8'(8'h11 * 8'(k + 1))) begin
        n_bad++;
        $display("FAIL rr_payload%0d: got %h want %h", k, cap[s_cap + 4*k + 3], 8'(8'h11 * 8'(k + 1)));
      end
    end
    n_cmp++;
    if (gap_q.size() - s_gap != 3) begin
      n_bad++;
      $display("FAIL rr_gap_count: got %0d want 3", gap_q.size() - s_gap);
    end
    for (int i = s_gap; i < gap_q.size(); i++) begin
      n_cmp++;
      if (gap_q[i] < 434) begin
        n_bad++;
        $display("FAIL rr_gap: got %0d clocks want >= 434", gap_q[i]);
      end
    end
  endtask

  task automatic test_single_pulse;
    bit ok;
    int s_cap, s_ack;
    do_reset();
    s_cap = cap.size();
    s_ack = ack_q.size();
    bus.req_data = 32'h00007700;
    bus.req = 4'b0010;
    @(negedge clk);
    bus.req = 4'b0000;
    wait_fc(16'd1, 1000, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL pulse_done: fc=%h want 0001", fc); end
    repeat (600) @(negedge clk);
    n_cmp++;
    if (fc !== 16'd1) begin n_bad++; $display("FAIL pulse_no_repeat: fc=%h want 0001", fc); end
    n_cmp++;
    if (ack_q.size() - s_ack != 1 || ack_q[s_ack] !== 4'b0010) begin
      n_bad++;
      $display("FAIL pulse_ack: count=%0d first=%b want 1 x 0010", ack_q.size() - s_ack, ack_q[s_ack]);
    end
    n_cmp++;
    if (cap.size() - s_cap != 4) begin
      n_bad++;
      $display("FAIL pulse_byte_count: got %0d want 4", cap.size() - s_cap);
    end
    n_cmp++;
    if (cap[s_cap + 2] !== 8'h02) begin
      n_bad++;
      $display("FAIL pulse_id: got %h want 02", cap[s_cap + 2]);
    end
    n_cmp++;
    if (cap[s_cap + 3] !== 8'h77) begin
      n_bad++;
      $display("FAIL pulse_payload: got %h want 77", cap[s_cap + 3]);
    end
  endtask

  task automatic test_timeout;
    bit found;
    int n, s_rises, s_ack;
    do_reset();
    tx_en = 1'b0;
    s_rises = valid_rises;
    s_ack = ack_q.size();
    bus.req_data = 32'h000000A5;
    bus.req = 4'b0001;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus.tx_data_valid;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL timeout_valid: valid never rose, want 1"); end
    n = 0;
    while (!error && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n != 8) begin n_bad++; $display("FAIL timeout_clocks: got %0d want 8", n); end
    n_cmp++;
    if (bus.tx_data_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_valid_low: got %b want 0", bus.tx_data_valid);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout_busy: got %b want 0", busy); end
    bus.req = 4'b0000;
    repeat (5) @(negedge clk);
    bus.req = 4'b0001;
    repeat (50) @(negedge clk);
    n_cmp++;
    if (valid_rises - s_rises != 1) begin
      n_bad++;
      $display("FAIL timeout_no_frames: valid rises %0d want 1", valid_rises - s_rises);
    end
    n_cmp++;
    if (fc !== 16'd0 || error !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_state: fc=%h err=%b want fc=0000 err=1", fc, error);
    end
    n_cmp++;
    if (ack_q.size() - s_ack != 1) begin
      n_bad++;
      $display("FAIL timeout_ack_count: got %0d want 1", ack_q.size() - s_ack);
    end
    bus.req = 4'b0000;
    tx_en = 1'b1;
  endtask

  task automatic test_reset_mid;
    bit found, ok;
    logic [3:0] seen;
    int s_cap, s_ack;
    do_reset();
    s_cap = cap.size();
    bus.req_data = 32'h00660000;
    bus.req = 4'b0100;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = (cap.size() >= s_cap + 3);
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL midrst_reach: bytes %0d want 3", cap.size() - s_cap); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.ack, bus.tx_data_valid, bus.tx_byte, busy, error, fc} !== 31'd0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got ack=%b v=%b byte=%h busy=%b err=%b fc=%h, want all zero",
               bus.ack, bus.tx_data_valid, bus.tx_byte, busy, error, fc);
    end
    bus.req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    s_cap = cap.size();
    s_ack = ack_q.size();
    bus.req = 4'b0101;
    wait_ack(20, seen);
    bus.req = 4'b0000;
    n_cmp++;
    if (seen !== 4'b0001) begin n_bad++; $display("FAIL midrst_next_grant: got %b want 0001", seen); end
    wait_fc(16'd1, 1000, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL midrst_done: fc=%h want 0001", fc); end
    n_cmp++;
    if (cap[s_cap + 2] !== 8'h01) begin
      n_bad++;
      $display("FAIL midrst_id: got %h want 01", cap[s_cap + 2]);
    end
    n_cmp++;
    if (ack_q.size() - s_ack != 1) begin
      n_bad++;
      $display("FAIL midrst_ack_count: got %0d want 1", ack_q.size() - s_ack);
    end
  endtask

  task automatic test_wrap;
    logic [3:0] seen;
    bit ok;
    do_reset();
    force dut.r_frame_count = 16'hFFFF;
    @(negedge clk);
    n_cmp++;
    if (fc !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_preload: got %h want ffff", fc); end
    release dut.r_frame_count;
    @(negedge clk);
    bus.req_data = 32'h99000000;
    bus.req = 4'b1000;
    wait_ack(20, seen);
    bus.req = 4'b0000;
    n_cmp++;
    if (seen !== 4'b1000) begin n_bad++; $display("FAIL wrap_ack: got %b want 1000", seen); end
    wait_fc(16'd0, 1000, ok);
    n_cmp++;
    if (!ok || fc !== 16'd0) begin
      n_bad++;
      $display("FAIL wrap_count: got %h want 0000", fc);
    end
  endtask

  task automatic test_ack_onehot;
    n_cmp++;
    if (ack_multi != 0) begin
      n_bad++;
      $display("FAIL ack_onehot: %0d multi-bit ack cycles want 0", ack_multi);
    end
  endtask

  initial begin
    rst          = 1'b1;
    tx_en        = 1'b1;
    bus.req      = 4'b0000;
    bus.req_data = 32'h0;
    test_reset();
    test_single();
    test_round_robin();
    test_single_pulse();
    test_timeout();
    test_reset_mid();
    test_wrap();
    test_ack_onehot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
